// File: rtl/pwm_peripheral.sv
// 16-pin output stage driven by SPI-written control registers: each pin is low,
// constant high, or follows one shared 8-bit PWM waveform with period-aligned duty updates.
module pwm_peripheral #(
  parameter int unsigned PRESCALE_DIV = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  localparam int unsigned PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       duty_shadow_q, duty_shadow_d;
  logic             load_pending_q, load_pending_d;
  logic [15:0]      pins_q, pins_d;
  logic             period_start_q, period_start_d;

  logic        tick;
  logic        wrap;
  logic [7:0]  duty_eff;
  logic        level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (pre_cnt_q == PRE_MAX);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  // While a post-reset load is pending the live duty drives the level, so the
  // very first step of the first period already uses the requested duty.
  assign duty_eff = load_pending_q ? pwm_duty_cycle : duty_shadow_q;
  assign level    = (duty_eff == 8'hFF) ? 1'b1 : (pwm_cnt_q < duty_eff);

  always_comb begin
    pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_shadow_d  = duty_shadow_q;
    load_pending_d = 1'b0;
    if (wrap || load_pending_q) begin
      duty_shadow_d = pwm_duty_cycle;
    end
    period_start_d = (pwm_cnt_q == 8'h00) && (pre_cnt_q == '0);
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pin
      assign pins_d[gi] = en_out[gi] & (~en_pwm[gi] | level);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= 8'h00;
      duty_shadow_q  <= 8'h00;
      load_pending_q <= 1'b1;
      pins_q         <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      load_pending_q <= load_pending_d;
      pins_q         <= pins_d;
      period_start_q <= period_start_d;
    end
  end

  assign uo_out       = pins_q[7:0];
  assign uio_out      = pins_q[15:8];
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at PRESCALE_DIV=13 (3328-clk period); all
// expected values are hand-computed from the duty and prescale.
module tb_pwm_peripheral;

  localparam int PERIOD = 3328;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] uo_out, uio_out;
  logic       period_start;

  int checks = 0;
  int passed = 0;

  pwm_peripheral #(.PRESCALE_DIV(13)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .uo_out         (uo_out),
    .uio_out        (uio_out),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Advances at least one cycle, then stops on the negedge where period_start is high.
  task automatic wait_period_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Samples n cycles from the current negedge, leaving the bench n cycles later.
  task automatic count_cycles(input int n, output int hi, output int lo, output int ps);
    logic [15:0] v;
    hi = 0; lo = 0; ps = 0;
    for (int i = 0; i < n; i++) begin
      v = {uio_out, uo_out};
      if (v === 16'hFFFF) hi++;
      else if (v === 16'h0000) lo++;
      if (period_start === 1'b1) ps++;
      @(negedge clk);
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    repeat (3) step();
    checks++; if (uo_out !== 8'h00) $display("FAIL reset_uo got=%h exp=00", uo_out); else passed++;
    checks++; if (uio_out !== 8'h00) $display("FAIL reset_uio got=%h exp=00", uio_out); else passed++;
    checks++; if (period_start !== 1'b0) $display("FAIL reset_ps got=%b exp=0", period_start); else passed++;
    rst = 1'b0;
    step();
    checks++; if (period_start !== 1'b1) $display("FAIL release_ps got=%b exp=1", period_start); else passed++;
    checks++; if ({uio_out, uo_out} !== 16'hFFFF) $display("FAIL release_pins got=%h exp=ffff", {uio_out, uo_out}); else passed++;
    step();
    checks++; if (period_start !== 1'b0) $display("FAIL release_ps_once got=%b exp=0", period_start); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_static();
    set_en(16'h8001, 16'h0000);
    step();
    checks++; if (uo_out !== 8'h01) $display("FAIL static_uo got=%h exp=01", uo_out); else passed++;
    checks++; if (uio_out !== 8'h80) $display("FAIL static_uio got=%h exp=80", uio_out); else passed++;
    set_en(16'h0000, 16'hFFFF);
    step();
    checks++; if ({uio_out, uo_out} !== 16'h0000) $display("FAIL static_off got=%h exp=0000", {uio_out, uo_out}); else passed++;
    $display("test_static done");
  endtask

  task automatic test_half();
    bit ok;
    int hi, lo, ps;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    wait_period_start(ok);
    checks++; if (!ok) $display("FAIL half_wait got=timeout exp=period_start"); else passed++;
    count_cycles(PERIOD, hi, lo, ps);
    checks++; if (hi !== 1664) $display("FAIL half_high got=%0d exp=1664", hi); else passed++;
    checks++; if (lo !== 1664) $display("FAIL half_low got=%0d exp=1664", lo); else passed++;
    checks++; if (ps !== 1) $display("FAIL half_ps_in_period got=%0d exp=1", ps); else passed++;
    checks++; if (period_start !== 1'b1) $display("FAIL half_spacing got=%b exp=1", period_start); else passed++;
    $display("test_half done hi=%0d lo=%0d", hi, lo);
  endtask

  task automatic test_extremes();
    bit ok;
    int hi, lo, ps;
    pwm_duty_cycle = 8'h00;
    wait_period_start(ok);
    checks++; if (!ok) $display("FAIL zero_wait got=timeout exp=period_start"); else passed++;
    for (int p = 0; p < 2; p++) begin
      count_cycles(PERIOD, hi, lo, ps);
      checks++; if (lo !== PERIOD) $display("FAIL zero_low p=%0d got=%0d exp=%0d", p, lo, PERIOD); else passed++;
    end
    set_en(16'hF0F0, 16'hCC00);
    step();
    checks++; if ({uio_out, uo_out} !== 16'h30F0) $display("FAIL mux_mixed got=%h exp=30f0", {uio_out, uo_out}); else passed++;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    wait_period_start(ok);
    checks++; if (!ok) $display("FAIL full_wait got=timeout exp=period_start"); else passed++;
    for (int p = 0; p < 2; p++) begin
      count_cycles(PERIOD, hi, lo, ps);
      checks++; if (hi !== PERIOD) $display("FAIL full_high p=%0d got=%0d exp=%0d", p, hi, PERIOD); else passed++;
    end
    checks++; if (period_start !== 1'b1) $display("FAIL full_spacing got=%b exp=1", period_start); else passed++;
    $display("test_extremes done");
  endtask

  task automatic test_buffering();
    int hi, lo, ps, hsum, lsum;
    // Period A: shadow still 0xFF although 0x40 is written now.
    pwm_duty_cycle = 8'h40;
    count_cycles(PERIOD, hi, lo, ps);
    checks++; if (hi !== PERIOD) $display("FAIL buf_hold_ff got=%0d exp=%0d", hi, PERIOD); else passed++;
    // Period B: 0x40 active, 0xC0 written mid-period while the pin is high.
    count_cycles(400, hi, lo, ps);
    hsum = hi; lsum = lo;
    pwm_duty_cycle = 8'hC0;
    count_cycles(PERIOD - 400, hi, lo, ps);
    hsum += hi; lsum += lo;
    checks++; if (hsum !== 832) $display("FAIL buf_cur_high got=%0d exp=832", hsum); else passed++;
    checks++; if (lsum !== 2496) $display("FAIL buf_cur_low got=%0d exp=2496", lsum); else passed++;
    // Period C: 0xC0 active; a write lands on the wrap cycle, then another one cycle later.
    count_cycles(PERIOD - 2, hi, lo, ps);
    hsum = hi;
    pwm_duty_cycle = 8'h10;
    count_cycles(1, hi, lo, ps);
    hsum += hi;
    pwm_duty_cycle = 8'hF0;
    count_cycles(1, hi, lo, ps);
    hsum += hi;
    checks++; if (hsum !== 2496) $display("FAIL buf_next_high got=%0d exp=2496", hsum); else passed++;
    checks++; if (period_start !== 1'b1) $display("FAIL buf_spacing got=%b exp=1", period_start); else passed++;
    count_cycles(PERIOD, hi, lo, ps);
    checks++; if (hi !== 208) $display("FAIL buf_wrap_write got=%0d exp=208", hi); else passed++;
    $display("test_buffering done");
  endtask

  task automatic test_reset_mid();
    int hi, lo, ps;
    // Bench sits at a period start with duty 0xF0; 714 cycles on, pwm_cnt is 0x37.
    count_cycles(714, hi, lo, ps);
    checks++; if ({uio_out, uo_out} !== 16'hFFFF) $display("FAIL mid_pre got=%h exp=ffff", {uio_out, uo_out}); else passed++;
    rst = 1'b1;
    pwm_duty_cycle = 8'h20;
    step();
    checks++; if ({uio_out, uo_out} !== 16'h0000) $display("FAIL mid_rst_pins got=%h exp=0000", {uio_out, uo_out}); else passed++;
    step();
    rst = 1'b0;
    step();
    checks++; if (period_start !== 1'b1) $display("FAIL mid_release_ps got=%b exp=1", period_start); else passed++;
    count_cycles(PERIOD, hi, lo, ps);
    checks++; if (hi !== 416) $display("FAIL mid_first_high got=%0d exp=416", hi); else passed++;
    checks++; if (lo !== 2912) $display("FAIL mid_first_low got=%0d exp=2912", lo); else passed++;
    checks++; if (period_start !== 1'b1) $display("FAIL mid_spacing got=%b exp=1", period_start); else passed++;
    $display("test_reset_mid done hi=%0d", hi);
  endtask

  initial begin
    rst = 1'b1;
    set_en(16'h0000, 16'h0000);
    pwm_duty_cycle = 8'h00;
    test_reset();
    test_static();
    test_half();
    test_extremes();
    test_buffering();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
